// File: rtl/dbfs_mul_pipe.sv
// dbfs_mul_pipe: ce-gated pipelined multiplier with post-scaling.
// Each operand is extended by one bit, sign- or zero-extended according to its
// signedness parameter. The product is computed at full precision, so it never
// overflows. That product is then optionally rounded half-up and arithmetically
// right-shifted. Finally it is range-checked against the signed DOUT range,
// where it either saturates or wraps.
// A valid bit travels with the data.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-low
//   ce        clock enable for every register
//   in_valid  din0/din1 carry a sample
//   din0      operand 0 (DIN0_WIDTH)
//   din1      operand 1 (DIN1_WIDTH)
//   out_valid dout/ovf carry a result
//   dout      scaled product, signed (DOUT_WIDTH)
//   ovf       scaled product fell outside the signed DOUT range
module dbfs_mul_pipe #(
    parameter int unsigned DIN0_WIDTH  = 16,
    parameter int unsigned DIN1_WIDTH  = 8,
    parameter int unsigned DOUT_WIDTH  = 24,
    parameter int unsigned NUM_STAGE   = 4,
    parameter int unsigned DIN0_SIGNED = 1,
    parameter int unsigned DIN1_SIGNED = 0,
    parameter int unsigned SHIFT       = 0,
    parameter int unsigned ROUND       = 0,
    parameter int unsigned SAT         = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int unsigned FULL = DIN0_WIDTH + DIN1_WIDTH + 1;
    localparam int unsigned RW   = FULL + 1;
    localparam int unsigned CW   = ((RW > DOUT_WIDTH) ? RW : DOUT_WIDTH) + 1;
    localparam int unsigned NDLY = NUM_STAGE - 2;

    localparam logic [RW-1:0] RND_ADD =
        (ROUND != 0 && SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [CW-1:0] OUT_MAX = $signed(CW'({(DOUT_WIDTH-1){1'b1}}));
    localparam logic signed [CW-1:0] OUT_MIN = ~OUT_MAX;

    // Stage 1: operand and valid capture
    logic [DIN0_WIDTH-1:0] din0_q;
    logic [DIN1_WIDTH-1:0] din1_q;
    logic                  vld1_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            din0_q <= '0;
            din1_q <= '0;
            vld1_q <= 1'b0;
        end else if (ce) begin
            din0_q <= din0;
            din1_q <= din1;
            vld1_q <= in_valid;
        end
    end

    // Full-precision signed product; FULL bits always hold the exact result
    logic                   op0_sx_c;
    logic                   op1_sx_c;
    logic signed [FULL-1:0] op0_c;
    logic signed [FULL-1:0] op1_c;
    logic signed [FULL-1:0] prod_c;

    assign op0_sx_c = (DIN0_SIGNED != 0) && din0_q[DIN0_WIDTH-1];
    assign op1_sx_c = (DIN1_SIGNED != 0) && din1_q[DIN1_WIDTH-1];
    assign op0_c    = $signed({{(FULL-DIN0_WIDTH){op0_sx_c}}, din0_q});
    assign op1_c    = $signed({{(FULL-DIN1_WIDTH){op1_sx_c}}, din1_q});
    assign prod_c   = op0_c * op1_c;

    // Product register plus pure delay stages; bypassed when NUM_STAGE is 2
    logic signed [FULL-1:0] pp_c;
    logic                   pp_vld_c;

    if (NDLY == 0) begin : g_no_dly
        assign pp_c     = prod_c;
        assign pp_vld_c = vld1_q;
    end else begin : g_dly
        localparam int unsigned DW = NDLY * FULL;

        logic [DW-1:0]   prod_q;
        logic [NDLY-1:0] vld_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                prod_q <= '0;
                vld_q  <= '0;
            end else if (ce) begin
                prod_q <= DW'({prod_q, prod_c});
                vld_q  <= NDLY'({vld_q, vld1_q});
            end
        end

        assign pp_c     = $signed(prod_q[DW-1 -: FULL]);
        assign pp_vld_c = vld_q[NDLY-1];
    end

    // Post-process: round half-up, arithmetic shift, range check, clamp or wrap
    logic signed [RW-1:0]   rnd_c;
    logic signed [RW-1:0]   shf_c;
    logic signed [CW-1:0]   chk_c;
    logic [DOUT_WIDTH-1:0]  dout_c;
    logic                   ovf_c;

    assign rnd_c = $signed({pp_c[FULL-1], pp_c} + RND_ADD);
    assign shf_c = rnd_c >>> SHIFT;
    assign chk_c = CW'(shf_c);

    always_comb begin
        ovf_c  = (chk_c > OUT_MAX) || (chk_c < OUT_MIN);
        dout_c = chk_c[DOUT_WIDTH-1:0];
        if (SAT != 0 && ovf_c) begin
            dout_c = chk_c[CW-1] ? OUT_MIN[DOUT_WIDTH-1:0] : OUT_MAX[DOUT_WIDTH-1:0];
        end
    end

    // Final stage: registered result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout      <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (ce) begin
            dout      <= dout_c;
            ovf       <= ovf_c;
            out_valid <= pp_vld_c;
        end
    end

endmodule

// File: tb/tb_dbfs_mul_pipe.sv
// Scoreboard bench for dbfs_mul_pipe.
// Five differently parameterised instances share one stimulus stream.
module tb_dbfs_mul_pipe;

    localparam int ND = 5;
    // Instance configurations:
    //   0 defaults
    //   1 rounding on
    //   2 rounding off with wrap
    //   3 saturating at NUM_STAGE 8
    //   4 wrapping at NUM_STAGE 2
    localparam int C_W0[ND] = '{16, 8, 8, 8, 8};
    localparam int C_W1[ND] = '{8, 8, 8, 8, 8};
    localparam int C_DW[ND] = '{24, 8, 8, 8, 8};
    localparam int C_NS[ND] = '{4, 3, 2, 8, 2};
    localparam int C_S0[ND] = '{1, 1, 1, 1, 1};
    localparam int C_S1[ND] = '{0, 1, 1, 1, 1};
    localparam int C_SH[ND] = '{0, 4, 4, 0, 0};
    localparam int C_RN[ND] = '{0, 1, 0, 0, 0};
    localparam int C_ST[ND] = '{1, 1, 0, 1, 0};

    typedef struct {
        logic [31:0] d;
        bit          o;
        longint      due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic [15:0] din0;
    logic [7:0]  din1;

    logic [23:0] dout_a;
    logic [7:0]  dout_b, dout_c, dout_d, dout_e;
    logic        vq[ND];
    logic        oq[ND];
    logic [31:0] dq[ND];

    exp_t   sbq[ND][$];
    exp_t   mon_e;
    longint edge_idx = 0;
    bit     ce_q = 1'b0;
    int     n_cmp = 0;
    int     n_bad = 0;

    always #5 clk = ~clk;

    dbfs_mul_pipe #(.DIN0_WIDTH(16), .DIN1_WIDTH(8), .DOUT_WIDTH(24), .NUM_STAGE(4),
        .DIN0_SIGNED(1), .DIN1_SIGNED(0), .SHIFT(0), .ROUND(0), .SAT(1)) u_a (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .out_valid(vq[0]), .dout(dout_a), .ovf(oq[0]));
    dbfs_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8), .NUM_STAGE(3),
        .DIN0_SIGNED(1), .DIN1_SIGNED(1), .SHIFT(4), .ROUND(1), .SAT(1)) u_b (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0[7:0]), .din1(din1),
        .out_valid(vq[1]), .dout(dout_b), .ovf(oq[1]));
    dbfs_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8), .NUM_STAGE(2),
        .DIN0_SIGNED(1), .DIN1_SIGNED(1), .SHIFT(4), .ROUND(0), .SAT(0)) u_c (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0[7:0]), .din1(din1),
        .out_valid(vq[2]), .dout(dout_c), .ovf(oq[2]));
    dbfs_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8), .NUM_STAGE(8),
        .DIN0_SIGNED(1), .DIN1_SIGNED(1), .SHIFT(0), .ROUND(0), .SAT(1)) u_d (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0[7:0]), .din1(din1),
        .out_valid(vq[3]), .dout(dout_d), .ovf(oq[3]));
    dbfs_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(8), .NUM_STAGE(2),
        .DIN0_SIGNED(1), .DIN1_SIGNED(1), .SHIFT(0), .ROUND(0), .SAT(0)) u_e (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0[7:0]), .din1(din1),
        .out_valid(vq[4]), .dout(dout_e), .ovf(oq[4]));

    assign dq[0] = 32'(dout_a);
    assign dq[1] = 32'(dout_b);
    assign dq[2] = 32'(dout_c);
    assign dq[3] = 32'(dout_d);
    assign dq[4] = 32'(dout_e);

    // Reference: integer arithmetic straight from the scaling rules
    function automatic exp_t model(input int id, input logic [15:0] a, input logic [7:0] b,
                                   input longint due);
        longint x, y, p, r, s, mx, mn;
        exp_t   e;
        x = longint'(a) & ((longint'(1) << C_W0[id]) - 1);
        y = longint'(b) & ((longint'(1) << C_W1[id]) - 1);
        if (C_S0[id] != 0 && x >= (longint'(1) << (C_W0[id] - 1))) x -= longint'(1) << C_W0[id];
        if (C_S1[id] != 0 && y >= (longint'(1) << (C_W1[id] - 1))) y -= longint'(1) << C_W1[id];
        p = x * y;
        r = p + ((C_RN[id] != 0 && C_SH[id] > 0) ? (longint'(1) << (C_SH[id] - 1)) : 0);
        s = r >>> C_SH[id];
        mx = (longint'(1) << (C_DW[id] - 1)) - 1;
        mn = -mx - 1;
        e.o = (s > mx) || (s < mn);
        if (C_ST[id] != 0 && e.o) s = (s > mx) ? mx : mn;
        e.d = 32'(s) & 32'((longint'(1) << C_DW[id]) - 1);
        e.due = due;
        return e;
    endfunction

    // Capture side: every ce-qualified edge out of reset counts; samples are scored
    always @(posedge clk) begin
        if (reset && ce) begin
            edge_idx = edge_idx + 1;
            if (in_valid) begin
                for (int i = 0; i < ND; i++)
                    sbq[i].push_back(model(i, din0, din1, edge_idx + C_NS[i] - 1));
            end
            ce_q = 1'b1;
        end else begin
            ce_q = 1'b0;
        end
    end

    // Monitor: after each ce-qualified edge, pop and compare presented results
    always @(negedge clk) begin
        if (ce_q) begin
            for (int i = 0; i < ND; i++) begin
                if (vq[i]) begin
                    n_cmp++;
                    if (sbq[i].size() == 0) begin
                        n_bad++;
                        $display("FAIL spurious_valid dut%0d edge %0d: got out_valid=1 required 0",
                                 i, edge_idx);
                    end else begin
                        mon_e = sbq[i].pop_front();
                        if (dq[i] !== mon_e.d || oq[i] !== mon_e.o || edge_idx != mon_e.due) begin
                            n_bad++;
                            $display("FAIL result dut%0d: got dout=%0h ovf=%0b edge=%0d required dout=%0h ovf=%0b edge=%0d",
                                     i, dq[i], oq[i], edge_idx, mon_e.d, mon_e.o, mon_e.due);
                        end
                    end
                end else if (sbq[i].size() != 0 && sbq[i][0].due <= edge_idx) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missing_valid dut%0d edge %0d: got out_valid=0 required 1 (due %0d)",
                             i, edge_idx, sbq[i][0].due);
                    void'(sbq[i].pop_front());
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] b, input logic v, input logic c);
        din0     = a;
        din1     = b;
        in_valid = v;
        ce       = c;
        @(posedge clk);
        #1;
    endtask

    // One sample, then hold operands so every instance settles on its result
    task automatic run_one(input logic [15:0] a, input logic [7:0] b);
        drive(a, b, 1'b1, 1'b1);
        repeat (9) drive(a, b, 1'b0, 1'b1);
    endtask

    task automatic chk_idle(input string nm);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("%s_dout%0d", nm, i), dq[i], 32'd0);
            chk($sformatf("%s_ovf%0d", nm, i), 32'(oq[i]), 32'd0);
            chk($sformatf("%s_valid%0d", nm, i), 32'(vq[i]), 32'd0);
        end
    endtask

    logic [31:0] snap_d[ND];
    logic        snap_o[ND];
    logic        snap_v[ND];

    initial begin
        reset = 1'b0; ce = 1'b0; in_valid = 1'b0; din0 = '0; din1 = '0;
        #1;
        chk_idle("reset_state");
        drive(16'd0, 8'd0, 1'b0, 1'b1);
        drive(16'd0, 8'd0, 1'b0, 1'b1);
        #3 reset = 1'b1;

        // Product and latency
        run_one(16'hFFFD, 8'd200);
        chk("prod_m3x200", dq[0], 32'h00FF_FDA8);
        chk("prod_m3x200_ovf", 32'(oq[0]), 32'd0);

        // Rounding, SHIFT=4
        run_one(16'd8, 8'd5);
        chk("rnd_40_r1", dq[1], 32'h03);
        chk("rnd_40_r0", dq[2], 32'h02);
        run_one(16'hFFF8, 8'd5);
        chk("rnd_m40_r1", dq[1], 32'hFE);
        chk("rnd_m40_r0", dq[2], 32'hFD);

        // Saturation and wrap, DOUT=8
        run_one(16'd100, 8'd100);
        chk("sat_pos", dq[3], 32'h7F);
        chk("sat_pos_ovf", 32'(oq[3]), 32'd1);
        chk("wrap_pos", dq[4], 32'h10);
        chk("wrap_pos_ovf", 32'(oq[4]), 32'd1);
        run_one(16'hFF9C, 8'd100);
        chk("sat_neg", dq[3], 32'h80);
        chk("sat_neg_ovf", 32'(oq[3]), 32'd1);

        // ce stall after edge 2; changed operands must not leak in while stalled
        drive(16'hFFFD, 8'd200, 1'b1, 1'b1);
        drive(16'hFFFD, 8'd200, 1'b0, 1'b1);
        for (int i = 0; i < ND; i++) begin
            snap_d[i] = dq[i]; snap_o[i] = oq[i]; snap_v[i] = vq[i];
        end
        for (int j = 0; j < 3; j++) begin
            drive(16'd7, 8'd9, 1'b1, 1'b0);
            for (int i = 0; i < ND; i++) begin
                chk($sformatf("stall_dout%0d", i), dq[i], snap_d[i]);
                chk($sformatf("stall_valid%0d", i), 32'(vq[i]), 32'(snap_v[i]));
                chk($sformatf("stall_ovf%0d", i), 32'(oq[i]), 32'(snap_o[i]));
            end
        end
        repeat (8) drive(16'hFFFD, 8'd200, 1'b0, 1'b1);
        chk("stall_m3x200", dq[0], 32'h00FF_FDA8);

        // Throughput: back-to-back samples
        for (int i = 0; i < 10; i++) drive(16'(i), 8'd3, 1'b1, 1'b1);
        repeat (10) drive(16'd9, 8'd3, 1'b0, 1'b1);
        chk("thru_last", dq[0], 32'd27);

        // Randomised traffic with ce gaps
        for (int n = 0; n < 400; n++)
            drive(16'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 4) != 0));
        repeat (12) drive(16'd0, 8'd0, 1'b0, 1'b1);

        // Reset mid-flight, asserted between edges
        drive(16'd1, 8'd2, 1'b1, 1'b1);
        drive(16'd3, 8'd4, 1'b1, 1'b1);
        drive(16'd5, 8'd6, 1'b1, 1'b1);
        #3 reset = 1'b0;
        for (int i = 0; i < ND; i++) sbq[i].delete();
        #1;
        chk_idle("midreset");
        drive(16'd0, 8'd0, 1'b0, 1'b1);
        drive(16'd0, 8'd0, 1'b0, 1'b1);
        #3 reset = 1'b1;
        for (int j = 0; j < 10; j++) begin
            drive(16'd0, 8'd0, 1'b0, 1'b1);
            for (int i = 0; i < ND; i++)
                chk($sformatf("post_reset_valid%0d", i), 32'(vq[i]), 32'd0);
        end

        // All scored samples must have been presented
        for (int i = 0; i < ND; i++)
            chk($sformatf("drain_dut%0d", i), 32'(sbq[i].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dbfs_mul_pipe.md
# dbfs_mul_pipe

Parametrised, ce-gated pipelined multiplier used by the dBFS conversion datapath. Each operand's signedness is set by a parameter. The full-precision product passes through a post-scaling stage with optional arithmetic right shift, round-half-up and saturation. A valid bit travels alongside the data, so downstream logic no longer counts latency by hand. It replaces the fixed-width, fixed-latency multiplier instances in the log/scale path.

## Interface
- DIN0_WIDTH, 16: width of operand 0.
- DIN1_WIDTH, 8: width of operand 1.
- DOUT_WIDTH, 24: width of the result, always signed two's complement.
- NUM_STAGE, 4: latency in ce-qualified clock edges. Legal range 2..8.
- DIN0_SIGNED, 1: operand 0 is signed (1) or unsigned (0).
- DIN1_SIGNED, 0: operand 1 is signed (1) or unsigned (0).
- SHIFT, 0: arithmetic right shift applied to the full product. Legal range 0..FULL-1.
- ROUND, 0: when 1 and SHIFT>0, add 2^(SHIFT-1) before the shift.
- SAT, 1: out-of-range results saturate (1) or wrap by LSB truncation (0).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- ce  in  1  clock enable for every register in the block.
- in_valid  in  1  din0/din1 carry a sample this cycle.
- din0  in  DIN0_WIDTH  operand 0.
- din1  in  DIN1_WIDTH  operand 1.
- out_valid  out  1  dout/ovf carry a result.
- dout  out  DOUT_WIDTH  scaled product.
- ovf  out  1  the scaled product fell outside the signed DOUT range.

## Operation
- Operand extension:
  - Each operand is extended to its width+1 bits: sign-extended when its *_SIGNED parameter is 1, zero-extended otherwise.
  - FULL = DIN0_WIDTH + DIN1_WIDTH + 1. The signed product is computed at FULL bits and never overflows.
- Stages:
  - Stage 1 registers din0, din1 and in_valid.
  - Stage 2 registers the full product.
  - Stages 3..NUM_STAGE-1 are pure delay registers.
  - The final stage registers the post-processed dout, ovf and out_valid.
  - When NUM_STAGE=2, post-processing sits in front of the stage-2 register.
- Post-process, in this order:
  - Rounding: r = p + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0), computed at FULL+1 bits.
  - Shift: s = r >>> SHIFT (arithmetic).
  - Range check: ovf = 1 when s > 2^(DOUT_WIDTH-1)-1 or s < -2^(DOUT_WIDTH-1).
  - Output: when SAT=1 and ovf=1, dout is clamped to max or min. Otherwise dout = s[DOUT_WIDTH-1:0].
- ovf is reported whenever the range is exceeded, regardless of the SAT setting.
- Data registers load unconditionally when ce=1; valid only qualifies them. dout/ovf may change while out_valid=0. Consumers must gate on out_valid.
- ce=0: every register, including the valid chain, holds its value. Outputs are frozen.
- No backpressure. Throughput is one sample per ce-high cycle.

## Timing
- Reset:
  - Reset asserted clears all stages immediately, without waiting for a clock edge: dout=0, ovf=0, out_valid=0, and every internal valid bit = 0.
  - Reset asserted mid-operation discards every in-flight sample. No stale out_valid appears after reset is released.
  - The first sample accepted is the one present on the first ce-high edge after reset deasserts.
- Latency:
  - A sample taken on ce-high edge k appears on dout/out_valid right after ce-high edge k+NUM_STAGE-1.
  - Equivalently, it is visible after NUM_STAGE ce-qualified edges, counting the capture edge.
  - ce-low cycles stretch the latency in wall-clock time but not in ce-high edges.
- out_valid pulses:
  - out_valid is high for exactly one ce-high cycle per accepted sample.
  - While ce=0, out_valid stays high if it was already high.
- Simultaneous events: reset overrides ce and in_valid.

## Test plan
- Product and latency: W0=16, W1=8, DOUT=24, SHIFT=0, DIN1_SIGNED=0, din0=-3, din1=200, in_valid for one cycle -> after 4 edges dout=-600, out_valid high for 1 cycle, ovf=0.
- ce stall: same sample, ce low for 3 cycles after edge 2 -> dout=-600 appears only after the 4th ce-high edge, and outputs do not change while ce=0.
- Rounding, SHIFT=4:
  - 8×5=40: ROUND=1 -> dout=3; ROUND=0 -> dout=2.
  - -8×5=-40: ROUND=1 -> dout=-2; ROUND=0 -> dout=-3.
- Saturation, DOUT=8, both operands signed:
  - 100×100 with SAT=1 -> dout=127, ovf=1.
  - -100×100 with SAT=1 -> dout=-128, ovf=1.
  - 100×100 with SAT=0 -> dout=16, ovf=1.
- Reset mid-flight: 3 samples in the pipe, pull reset low between clock edges -> dout=0, ovf=0, out_valid=0 at once. After release with in_valid=0 and ce=1 for 10 cycles, out_valid stays 0.
- Throughput: 10 back-to-back samples din0=i, din1=3 -> 10 consecutive out_valid cycles with dout=0,3,...,27 in order, no gaps or duplicates.
